// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: shared EX-stage definitions for the divide sequencer.
// Holds the datapath width, FUNCT codes (including DIV/DIVU), the divider
// state encoding and the iteration count.
package ex_div_ctrl_pkg;
    localparam int DATA_BUS   = 32;
    localparam int DIV_CYCLES = 32;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;
    function automatic logic is_div_funct(input logic [5:0] f);
        return f == FUNCT_DIV || f == FUNCT_DIVU;
    endfunction
endpackage

// File: rtl/ex_div_ctrl_if.sv
// ex_div_ctrl_if: EX-stage <-> divide sequencer bundle.
// master (EX side) drives flush, div_en, div_signed, operand_1, operand_2;
// slave (divider) drives stall_req, done, result_lo, result_hi.
interface ex_div_ctrl_if #(parameter int DIV_WIDTH = 32);
    logic                 flush;
    logic                 div_en;
    logic                 div_signed;
    logic [DIV_WIDTH-1:0] operand_1;
    logic [DIV_WIDTH-1:0] operand_2;
    logic                 stall_req;
    logic                 done;
    logic [DIV_WIDTH-1:0] result_lo;
    logic [DIV_WIDTH-1:0] result_hi;
    modport master (
        output flush, div_en, div_signed, operand_1, operand_2,
        input  stall_req, done, result_lo, result_hi
    );
    modport slave (
        input  flush, div_en, div_signed, operand_1, operand_2,
        output stall_req, done, result_lo, result_hi
    );
endinterface

// File: rtl/ex_div_ctrl_div_step.sv
// div_step: one combinational restoring-division step.
// Ports: i_pr (2W partial remainder, upper = remainder, lower = dividend/quotient),
//        i_divisor (W), o_pr (next partial remainder), o_q_bit (quotient bit).
module div_step #(parameter int W = 32) (
    input  logic [2*W-1:0] i_pr,
    input  logic [W-1:0]   i_divisor,
    output logic [2*W-1:0] o_pr,
    output logic           o_q_bit
);
    logic [W+1:0] w_diff;
    // The shifted upper half needs W+1 bits: the bit leaving i_pr[2W-1] still counts.
    assign w_diff  = {1'b0, i_pr[2*W-1:W-1]} - {2'b00, i_divisor};
    assign o_q_bit = ~w_diff[W+1];
    assign o_pr    = {o_q_bit ? w_diff[W-1:0] : i_pr[2*W-2:W-1], i_pr[W-2:0], o_q_bit};
endmodule

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle restoring DIV/DIVU sequencer for the EX stage.
// Ports: clk, rst (sync, active-high); bus (ex_div_ctrl_if.slave):
//   in  flush, div_en, div_signed, operand_1 (dividend), operand_2 (divisor)
//   out stall_req (combinational), done (1-cycle pulse), result_lo (quotient),
//       result_hi (remainder).
// Option: DIV_ZERO_FAST_EN sends a zero divisor straight from IDLE to DONE.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = DATA_BUS
) (
    input  logic clk,
    input  logic rst,
    ex_div_ctrl_if.slave bus
);
    localparam int W = DIV_WIDTH;
    div_state_e     r_state, w_next;
    logic [2*W-1:0] r_pr, w_pr_next;
    logic [W-1:0]   r_divisor, r_op1, r_lo, r_hi, w_mag1, w_mag2, w_q, w_r;
    logic [5:0]     r_cnt;
    logic           r_q_neg, r_r_neg, r_div0;
    logic           w_q_bit, w_s1, w_s2, w_zero, w_start, w_last, w_fast;

    div_step #(.W(W)) u_step (
        .i_pr      (r_pr),
        .i_divisor (r_divisor),
        .o_pr      (w_pr_next),
        .o_q_bit   (w_q_bit)
    );

    assign w_s1    = bus.div_signed & bus.operand_1[W-1];
    assign w_s2    = bus.div_signed & bus.operand_2[W-1];
    assign w_mag1  = w_s1 ? -bus.operand_1 : bus.operand_1;
    assign w_mag2  = w_s2 ? -bus.operand_2 : bus.operand_2;
    assign w_zero  = bus.operand_2 == '0;
    assign w_start = r_state == DIV_IDLE && bus.div_en && !bus.flush;
    assign w_last  = r_state == DIV_BUSY && r_cnt == 6'(W-1);
`ifdef DIV_ZERO_FAST_EN
    assign w_fast  = w_start & w_zero;
`else
    assign w_fast  = 1'b0;
`endif
    // Divide by zero is forced rather than left to the sign fixup.
    assign w_q = r_div0 ? '1 : r_q_neg ? -w_pr_next[W-1:0] : w_pr_next[W-1:0];
    assign w_r = r_div0 ? r_op1 : r_r_neg ? -w_pr_next[2*W-1:W] : w_pr_next[2*W-1:W];

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: w_next = w_fast ? DIV_DONE : w_start ? DIV_BUSY : DIV_IDLE;
            DIV_BUSY: w_next = bus.flush ? DIV_IDLE : w_last ? DIV_DONE : DIV_BUSY;
            default:  w_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr      <= '0;
            r_divisor <= '0;
            r_op1     <= '0;
            r_cnt     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_div0    <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
        end else begin
            if (w_start) begin
                r_pr      <= {{W{1'b0}}, w_mag1};
                r_divisor <= w_mag2;
                r_op1     <= bus.operand_1;
                r_cnt     <= '0;
                r_q_neg   <= w_s1 ^ w_s2;
                r_r_neg   <= w_s1;
                r_div0    <= w_zero;
            end else if (r_state == DIV_BUSY) begin
                r_pr  <= w_pr_next;
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_fast) begin
                r_lo <= '1;
                r_hi <= bus.operand_1;
            end else if (w_last && !bus.flush) begin
                r_lo <= w_q;
                r_hi <= w_r;
            end
        end
    end

    assign bus.stall_req = w_start | (r_state == DIV_BUSY);
    assign bus.done      = r_state == DIV_DONE && !bus.flush;
    assign bus.result_lo = r_lo;
    assign bus.result_hi = r_hi;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: self-checking bench for ex_div_ctrl (directed table, corner sequences, random vs model).
module tb_ex_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass = 0;
    int   total = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_div_ctrl_if #(.DIV_WIDTH(32)) bus ();
    ex_div_ctrl #(.DIV_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return b == 0 ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; cycle 0 is the issue cycle.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output int dcyc,
                          output logic [31:0] q, output logic [31:0] r);
        bus.div_en = 1'b1;
        bus.div_signed = sg;
        bus.operand_1 = a;
        bus.operand_2 = b;
        lat = -1;
        stalls = 0;
        dcyc = 0;
        q = 'x;
        r = 'x;
        for (int c = 0; c < 100 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.stall_req) stalls++;
            if (bus.done) begin
                lat = c;
                dcyc = cyc;
                q = bus.result_lo;
                r = bus.result_hi;
            end
            @(posedge clk);
            #1;
        end
        bus.div_en = 1'b0;
    endtask

    vec_t        vt[10];
    int          lat, stalls, d1, d2, ndone;
    logic [31:0] q, r, eq, er, plo, phi;

    initial begin
        vt[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2};
        vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vt[2] = '{1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vt[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vt[4] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        vt[5] = '{1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5};
        vt[6] = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5};
        vt[7] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
        vt[8] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF};
        vt[9] = '{1'b1, 32'd0, 32'd5, 32'd0, 32'd0};
        bus.flush = 1'b0;
        bus.div_en = 1'b0;
        bus.div_signed = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset stall_req", 32'(bus.stall_req), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset result_lo", bus.result_lo, 0);
        chk("reset result_hi", bus.result_hi, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_div(vt[i].sg, vt[i].a, vt[i].b, lat, stalls, d1, q, r);
            chk($sformatf("vec%0d q", i), q, vt[i].q);
            chk($sformatf("vec%0d r", i), r, vt[i].r);
            chk($sformatf("vec%0d latency", i), lat, exp_lat(vt[i].b));
            chk($sformatf("vec%0d stalls", i), stalls, exp_lat(vt[i].b));
        end

        // Flush while BUSY at cycle 10.
        plo = bus.result_lo;
        phi = bus.result_hi;
        bus.div_en = 1'b1;
        bus.div_signed = 1'b0;
        bus.operand_1 = 32'd1000;
        bus.operand_2 = 32'd3;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        chk("flush busy stall same cycle", 32'(bus.stall_req), 1);
        chk("flush busy done", 32'(bus.done), 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.div_en = 1'b0;
        ndone = 0;
        @(negedge clk);
        chk("flush busy stall next cycle", 32'(bus.stall_req), 0);
        repeat (40) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("flush no done pulse", ndone, 0);
        chk("flush lo unchanged", bus.result_lo, plo);
        chk("flush hi unchanged", bus.result_hi, phi);
        @(posedge clk);
        #1;
        do_div(1'b0, 32'd1000, 32'd3, lat, stalls, d1, q, r);
        chk("after flush q", q, 32'd333);
        chk("after flush r", r, 32'd1);
        chk("after flush latency", lat, 33);

        // Flush in IDLE beats div_en.
        bus.div_en = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("idle flush stall", 32'(bus.stall_req), 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.div_en = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.stall_req) ndone++;
        end
        chk("idle flush no activity", ndone, 0);
        @(posedge clk);
        #1;

        // Reset at BUSY cycle 20.
        bus.div_en = 1'b1;
        bus.operand_1 = 32'd77;
        bus.operand_2 = 32'd5;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.div_en = 1'b0;
        @(negedge clk);
        chk("mid rst stall", 32'(bus.stall_req), 0);
        chk("mid rst done", 32'(bus.done), 0);
        chk("mid rst lo", bus.result_lo, 0);
        chk("mid rst hi", bus.result_hi, 0);
        @(posedge clk);
        #1;

        // Back-to-back divides.
        do_div(1'b0, 32'd9, 32'd3, lat, stalls, d1, q, r);
        chk("b2b1 q", q, 32'd3);
        chk("b2b1 r", r, 32'd0);
        do_div(1'b0, 32'd10, 32'd4, lat, stalls, d2, q, r);
        chk("b2b2 q", q, 32'd2);
        chk("b2b2 r", r, 32'd2);
        chk("b2b done spacing", d2 - d1, 34);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            logic        sg;
            logic [31:0] a, b;
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 1000);
            endcase
            ref_div(sg, a, b, eq, er);
            do_div(sg, a, b, lat, stalls, d1, q, r);
            chk($sformatf("rand%0d q (%0d %h/%h)", i, sg, a, b), q, eq);
            chk($sformatf("rand%0d r (%0d %h/%h)", i, sg, a, b), r, er);
            chk($sformatf("rand%0d latency", i), lat, exp_lat(b));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
